// File: rtl/booth_seq_multiplier_if.sv
// Start/done handshake and operand/result bus of the sequential Booth multiplier.
// Master drives the request side; slave (the multiplier) drives busy, done and product.
interface booth_seq_multiplier_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, signed_mode, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, signed_mode, a, b,
      output busy, done, product
   );
endinterface

// File: rtl/booth_seq_multiplier.sv
// Radix-2 Booth multiplier: one iteration per cycle, done WIDTH+1 cycles after an accepted start.
// start is ignored while busy; no input-to-output combinational path.
module booth_seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   booth_seq_multiplier_if.slave         mul
);
   localparam int W1 = WIDTH + 1;
   localparam int CW = $clog2(W1 + 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [W1-1:0]       r_m;
   logic [W1-1:0]       r_acc;
   logic [W1-1:0]       r_q;
   logic                r_qm1;
   logic [CW-1:0]       r_cnt;
   logic                r_done;
   logic [2*WIDTH-1:0]  r_product;

   logic                w_accept;
   logic                w_last;
   logic [W1-1:0]       w_a_ext;
   logic [W1-1:0]       w_b_ext;
   logic [W1-1:0]       w_acc_op;
   logic [2*W1:0]       w_shift;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (mul.start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last)    w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_accept = (r_state == S_IDLE) && mul.start;
      w_last   = (r_state == S_RUN) && (r_cnt == CW'(1));
   end

   // Extending by one bit turns both signed and unsigned operands into a signed W1-bit problem.
   assign w_a_ext = {mul.signed_mode & mul.a[WIDTH-1], mul.a};
   assign w_b_ext = {mul.signed_mode & mul.b[WIDTH-1], mul.b};

   always_comb begin
      case ({r_q[0], r_qm1})
         2'b10:   w_acc_op = r_acc - r_m;
         2'b01:   w_acc_op = r_acc + r_m;
         default: w_acc_op = r_acc;
      endcase
      w_shift = {w_acc_op[W1-1], w_acc_op, r_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m   <= '0;
         r_acc <= '0;
         r_q   <= '0;
         r_qm1 <= 1'b0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_m   <= w_a_ext;
         r_acc <= '0;
         r_q   <= w_b_ext;
         r_qm1 <= 1'b0;
         r_cnt <= CW'(W1);
      end else if (r_state == S_RUN) begin
         r_acc <= w_shift[2*W1:W1+1];
         r_q   <= w_shift[W1:1];
         r_qm1 <= w_shift[0];
         r_cnt <= r_cnt - CW'(1);
      end
   end

   // The top two bits of the shifted {ACC,Q} are pure extension and are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         r_done <= w_last;
         if (w_last) begin
            r_product <= w_shift[2*WIDTH:1];
         end
      end
   end

   assign mul.busy    = (r_state == S_RUN);
   assign mul.done    = r_done;
   assign mul.product = r_product;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed and exhaustive checks of booth_seq_multiplier at WIDTH=8 and WIDTH=4.
module tb_booth_seq_multiplier;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   booth_seq_multiplier_if #(.WIDTH(8)) m8 ();
   booth_seq_multiplier_if #(.WIDTH(4)) m4 ();

   booth_seq_multiplier #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .mul(m8.slave));
   booth_seq_multiplier #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .mul(m4.slave));

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected simulation end");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic cur_busy(input int w);
      return (w == 8) ? m8.busy : m4.busy;
   endfunction

   function automatic logic cur_done(input int w);
      return (w == 8) ? m8.done : m4.done;
   endfunction

   function automatic logic [15:0] cur_prod(input int w);
      return (w == 8) ? m8.product : {8'h00, m4.product};
   endfunction

   task automatic drive(input int w, input logic st, input logic mode,
                        input logic [7:0] av, input logic [7:0] bv);
      if (w == 8) begin
         m8.start = st; m8.signed_mode = mode; m8.a = av; m8.b = bv;
      end else begin
         m4.start = st; m4.signed_mode = mode; m4.a = av[3:0]; m4.b = bv[3:0];
      end
   endtask

   // Issues one operation and waits for done; lat counts edges from the accept edge to done.
   task automatic run_op(input int w, input logic mode, input logic [7:0] av, input logic [7:0] bv,
                         input bit hold, input bit disturb,
                         output logic [15:0] p, output int lat);
      bit busy_ok;
      bit d;
      @(negedge clk);
      drive(w, 1'b1, mode, av, bv);
      @(posedge clk); #1;
      if (!hold) begin
         if (w == 8) m8.start = 1'b0; else m4.start = 1'b0;
      end
      busy_ok = 1'b1;
      d = 1'b0;
      lat = 0;
      while (lat < 30 && !d) begin
         if (!cur_busy(w)) busy_ok = 1'b0;
         if (disturb && lat == 3) begin
            m8.start = 1'b1; m8.a = 8'h07; m8.b = 8'h09;
         end
         if (disturb && lat == 5) m8.start = 1'b0;
         @(posedge clk); #1;
         lat++;
         d = cur_done(w);
      end
      p = cur_prod(w);
      check($sformatf("w%0d busy_during_run", w), 64'(busy_ok), 64'd1);
      check($sformatf("w%0d busy_at_done", w), 64'(cur_busy(w)), 64'd0);
   endtask

   logic [15:0] p;
   int          lat;
   int          sa, sb, ev;
   bit          saw_done;

   initial begin
      drive(8, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(4, 1'b0, 1'b0, 8'h00, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      check("rst busy8", 64'(m8.busy), 64'd0);
      check("rst done8", 64'(m8.done), 64'd0);
      check("rst prod8", 64'(m8.product), 64'd0);
      check("rst busy4", 64'(m4.busy), 64'd0);
      check("rst prod4", 64'(m4.product), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // -128 x -128
      run_op(8, 1'b1, 8'h80, 8'h80, 1'b0, 1'b0, p, lat);
      check("neg128sq prod", 64'(p), 64'h4000);
      check("neg128sq lat", 64'(lat), 64'd9);
      @(posedge clk); #1;
      check("done one pulse", 64'(m8.done), 64'd0);
      check("prod holds", 64'(m8.product), 64'h4000);

      run_op(8, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, p, lat);
      check("uFFxFF prod", 64'(p), 64'hFE01);
      check("uFFxFF lat", 64'(lat), 64'd9);
      run_op(8, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, p, lat);
      check("sFFxFF prod", 64'(p), 64'h0001);

      // Hold start through the done cycle; the second op starts at the edge ending it.
      run_op(8, 1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, p, lat);
      check("m1x1 prod", 64'(p), 64'hFFFF);
      check("m1x1 lat", 64'(lat), 64'd9);
      m8.a = 8'h07;
      m8.b = 8'hFA;
      @(posedge clk); #1;
      check("b2b accepted", 64'(m8.busy), 64'd1);
      m8.start = 1'b0;
      lat = 0;
      while (lat < 30 && !m8.done) begin
         @(posedge clk); #1;
         lat++;
      end
      check("b2b lat", 64'(lat), 64'd9);
      check("b2b prod", 64'(m8.product), 64'hFFD6);

      run_op(8, 1'b1, 8'h03, 8'h05, 1'b0, 1'b1, p, lat);
      check("ignore start prod", 64'(p), 64'h000F);
      check("ignore start lat", 64'(lat), 64'd9);
      @(posedge clk); #1;
      check("ignore start idle", 64'(m8.busy), 64'd0);

      // Abort mid-run with reset.
      @(negedge clk);
      drive(8, 1'b1, 1'b1, 8'h11, 8'h22);
      @(posedge clk); #1;
      m8.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort busy", 64'(m8.busy), 64'd0);
      check("abort done", 64'(m8.done), 64'd0);
      check("abort prod", 64'(m8.product), 64'd0);
      saw_done = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (m8.done) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (m8.done || m8.busy) saw_done = 1'b1;
      end
      check("abort no done", 64'(saw_done), 64'd0);
      run_op(8, 1'b1, 8'h02, 8'hFD, 1'b0, 1'b0, p, lat);
      check("2xm3 prod", 64'(p), 64'hFFFA);
      check("2xm3 lat", 64'(lat), 64'd9);

      for (int mode = 0; mode < 2; mode++) begin
         for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
               run_op(4, mode[0], 8'(ai), 8'(bi), 1'b0, 1'b0, p, lat);
               sa = (mode == 1 && ai >= 8) ? ai - 16 : ai;
               sb = (mode == 1 && bi >= 8) ? bi - 16 : bi;
               ev = (sa * sb) & 8'hFF;
               check($sformatf("w4 m%0d a%0d b%0d prod", mode, ai, bi), 64'(p), 64'(ev));
               check($sformatf("w4 m%0d a%0d b%0d lat", mode, ai, bi), 64'(lat), 64'd5);
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/booth_seq_multiplier.md
# booth_seq_multiplier

Parametrised sequential radix-2 Booth multiplier with a start/done handshake and selectable signed or unsigned operands. It is the general-width successor to the team's fixed 4-bit signed shift-add Booth multiplier. It adds explicit reset, operand capture, a busy/done protocol and unsigned support. It sits beside the datapath ALUs as a low-area multi-cycle multiply unit.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only when the unit is idle.
- signed_mode  input  1  1 = a and b are two's complement; 0 = both are unsigned. Captured with the operands.
- a  input  WIDTH  multiplicand; captured on accepted start.
- b  input  WIDTH  multiplier; captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; product is valid in the same cycle.
- product  output  2*WIDTH  registered result; holds its value until the next done.

## Operation
- Internal width W1 = WIDTH+1.
  - Operands are sign-extended when signed_mode=1 and zero-extended when signed_mode=0.
  - This makes both modes one signed W1-bit Booth problem.
- Registers:
  - M: W1 bits, extended a.
  - ACC: W1 bits, zeroed on start.
  - Q: W1 bits, extended b.
  - q_m1: 1 bit, zeroed on start.
  - cnt: counts W1 iterations.
  - state.
- The FSM has two states, IDLE and RUN; reset enters IDLE.
- IDLE:
  - If start=1, capture M, Q and the mode, clear ACC and q_m1, set cnt=W1, and go to RUN.
  - Otherwise remain in IDLE.
- RUN: each cycle performs one iteration.
  - If {Q[0],q_m1}=10, ACC = ACC − M.
  - If {Q[0],q_m1}=01, ACC = ACC + M.
  - If {Q[0],q_m1} is 00 or 11, ACC is unchanged.
  - Then {ACC,Q,q_m1} is shifted right arithmetically by 1 (the ACC MSB is replicated) and cnt decrements.
- Final iteration (cnt=1):
  - product ← low 2*WIDTH bits of the shifted {ACC,Q}.
  - done=1 for one cycle.
  - State returns to IDLE.
- Arithmetic: ACC add/sub is modulo 2^W1. |M| ≤ 2^WIDTH, so no overflow can corrupt the result. The discarded upper 2 bits are pure sign/zero extension.
- start is ignored while busy=1; a, b and signed_mode may change freely during RUN without effect.
- Reset values: busy=0, done=0, product=0, state=IDLE, and all internal registers are 0.
- Reset mid-operation aborts immediately. No done is produced and product reads 0.

## Timing
- Latency: start sampled high at edge k → done=1 and product valid after edge k+W1 (WIDTH+1 cycles).
- busy is high after edges k .. k+W1−1 and low in the done cycle.
- Throughput: start may be held or re-asserted in the done cycle. It is then accepted at edge k+W1, giving back-to-back operations every W1 cycles.
- done is never high for two consecutive cycles unless WIDTH+1 = 1, which cannot occur since WIDTH ≥ 2.
- done and busy are never high together.
- product changes only at a done edge or at reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, signed_mode=1, a=0x80, b=0x80 (−128×−128) → product=0x4000 after exactly 9 cycles, done pulses once.
- WIDTH=8, signed_mode=0, a=0xFF, b=0xFF → product=0xFE01. The same operands with signed_mode=1 → product=0x0001.
- WIDTH=8, signed a=0xFF (−1), b=0x01 → product=0xFFFF. Then hold start high: the second op is accepted in the done cycle and its done arrives 9 cycles later.
- Start pulsed again and a/b changed mid-RUN (a=3, b=5 then a=7) → ignored; product=0x000F.
- rst_n low at RUN cycle 4 → busy, done and product are 0 immediately, with no done. After release, a new start (a=2, b=−3 signed) → 0xFFFA.
- WIDTH=4, exhaustive: all 256 operand pairs × both modes checked against a reference model, with latency=5 on every operation.
